// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multicycle control FSM and the datapath.
// master: the control FSM side; slave: the datapath / memory side.
interface mc_ctrl_fsm_if;
    logic [5:0] op_i6;
    logic       zero_i;
    logic       mem_ready_i;
    logic       pc_we_o;
    logic       instr_or_data_o;
    logic       instr_we_o;
    logic       mem_we_o;
    logic       enable_wrf_o;
    logic       reg_dst_o;
    logic       mem_to_reg_o;
    logic       a_alu_input_o;
    logic [1:0] b_alu_input_o2;
    logic [1:0] alu_alt_ctrl_o2;
    logic [1:0] pc_src_o2;
    logic       illegal_op_o;
    logic [3:0] state_o4;

    modport master (
        input  op_i6, zero_i, mem_ready_i,
        output pc_we_o, instr_or_data_o, instr_we_o, mem_we_o, enable_wrf_o,
               reg_dst_o, mem_to_reg_o, a_alu_input_o, b_alu_input_o2,
               alu_alt_ctrl_o2, pc_src_o2, illegal_op_o, state_o4
    );

    modport slave (
        output op_i6, zero_i, mem_ready_i,
        input  pc_we_o, instr_or_data_o, instr_we_o, mem_we_o, enable_wrf_o,
               reg_dst_o, mem_to_reg_o, a_alu_input_o, b_alu_input_o2,
               alu_alt_ctrl_o2, pc_src_o2, illegal_op_o, state_o4
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Main control FSM of the multicycle MIPS core: sequences fetch, decode,
// execute, memory and writeback, and drives all datapath enables and selects.
module mc_ctrl_fsm #(
    parameter bit USE_MEM_READY = 1'b1
) (
    input logic           clk_i,
    input logic           reset_i,
    mc_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    state_e     state_q, state_d;
    logic       ready;
    logic       pc_we, instr_we, mem_we, enable_wrf;
    logic       instr_or_data, reg_dst, mem_to_reg, a_alu, illegal_op;
    logic [1:0] b_alu, alu_op, pc_src;

    assign ready = USE_MEM_READY ? bus.mem_ready_i : 1'b1;

    // State register; reset returns to FETCH without waiting for a clock edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and Moore output decode (pc_we and FETCH enables also see inputs).
    always_comb begin
        state_d       = StFetch;
        pc_we         = 1'b0;
        instr_we      = 1'b0;
        mem_we        = 1'b0;
        enable_wrf    = 1'b0;
        instr_or_data = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        a_alu         = 1'b0;
        b_alu         = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        illegal_op    = 1'b0;
        case (state_q)
            StFetch: begin
                b_alu    = 2'b01;
                instr_we = ready;
                pc_we    = ready;
                state_d  = ready ? StDecode : StFetch;
            end
            StDecode: begin
                // Precompute the branch target into ALUOut.
                b_alu = 2'b11;
                case (bus.op_i6)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default: begin
                        state_d    = StFetch;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            StMemAdr: begin
                a_alu   = 1'b1;
                b_alu   = 2'b10;
                // MEMADR is only entered for lw/sw, so anything but lw is a store.
                state_d = (bus.op_i6 == OpLw) ? StMemRd : StMemWr;
            end
            StMemRd: begin
                instr_or_data = 1'b1;
                state_d       = ready ? StMemWb : StMemRd;
            end
            StMemWb: begin
                mem_to_reg = 1'b1;
                enable_wrf = 1'b1;
                state_d    = StFetch;
            end
            StMemWr: begin
                instr_or_data = 1'b1;
                mem_we        = 1'b1;
                state_d       = ready ? StFetch : StMemWr;
            end
            StExecute: begin
                a_alu   = 1'b1;
                alu_op  = 2'b10;
                state_d = StAluWb;
            end
            StAluWb: begin
                reg_dst    = 1'b1;
                enable_wrf = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                a_alu   = 1'b1;
                alu_op  = 2'b01;
                pc_src  = 2'b01;
                pc_we   = bus.zero_i;
                state_d = StFetch;
            end
            StAddiEx: begin
                a_alu   = 1'b1;
                b_alu   = 2'b10;
                state_d = StAddiWb;
            end
            StAddiWb: begin
                enable_wrf = 1'b1;
                state_d    = StFetch;
            end
            StJump: begin
                pc_src  = 2'b10;
                pc_we   = 1'b1;
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase
    end

    // Write strobes are blocked while reset is held so an abandoned
    // instruction can never commit anything.
    assign bus.pc_we_o         = pc_we & ~reset_i;
    assign bus.instr_we_o      = instr_we & ~reset_i;
    assign bus.mem_we_o        = mem_we & ~reset_i;
    assign bus.enable_wrf_o    = enable_wrf & ~reset_i;
    assign bus.instr_or_data_o = instr_or_data;
    assign bus.reg_dst_o       = reg_dst;
    assign bus.mem_to_reg_o    = mem_to_reg;
    assign bus.a_alu_input_o   = a_alu;
    assign bus.b_alu_input_o2  = b_alu;
    assign bus.alu_alt_ctrl_o2 = alu_op;
    assign bus.pc_src_o2       = pc_src;
    assign bus.illegal_op_o    = illegal_op;
    assign bus.state_o4        = state_q;

endmodule
